// File: rtl/onehot_chk_pkg.sv
// Shared types for the one-hot phase stream checker: FSM states and per-sample classes.
// Purely declarative; no latency or flow-control behaviour of its own.
package onehot_chk_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_ILLEGAL = 2'd0,
    CLS_HOLD    = 2'd1,
    CLS_ADV     = 2'd2,
    CLS_SKIP    = 2'd3
  } cls_t;

endpackage

// File: rtl/onehot_classify.sv
// Combinational classifier of a phase sample against the previous legal phase, plus index decode.
// Zero latency, no flow control; idx is only meaningful when cls is not CLS_ILLEGAL.
module onehot_classify
  import onehot_chk_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] s,
  output cls_t             cls,
  output logic [IW-1:0]    idx
);

  logic [WIDTH-1:0] rot;
  logic             onehot;

  assign rot    = {prev[WIDTH-2:0], prev[WIDTH-1]};
  assign onehot = (s != '0) && ((s & (s - WIDTH'(1))) == '0);

  // OR-ing the positions of set bits yields the binary index for a one-hot input.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i]) idx = idx | IW'(i);
    end
  end

  always_comb begin
    cls = CLS_SKIP;
    if (!onehot)         cls = CLS_ILLEGAL;
    else if (s == prev)  cls = CLS_HOLD;
    else if (s == rot)   cls = CLS_ADV;
  end

endmodule

// File: rtl/onehot_seq_checker.sv
// Receive-side lock/fault checker for a rotating one-hot phase stream; outputs registered, 1-cycle latency.
// No backpressure: en gates sampling only. ONEHOT_CHK_TIMEOUT_EN adds a stall detector (HOLD_MAX) in LOCKED.
module onehot_seq_checker
  import onehot_chk_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int LOCK_COUNT    = 2,
  parameter int ERR_CNT_WIDTH = 8,
  parameter int HOLD_MAX      = 3,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         phase,
  output logic [IW-1:0]            idx,
  output logic                     locked,
  output logic                     fault,
  output logic                     adv_pulse,
  output logic                     err_pulse,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);

  state_t                   state, state_nxt;
  logic [WIDTH-1:0]         prev, prev_nxt;
  logic [MW-1:0]            match_cnt, match_nxt;
  logic [IW-1:0]            idx_nxt, s_idx;
  logic [ERR_CNT_WIDTH-1:0] cnt_nxt;
  logic                     adv_nxt, err_nxt, fault_entry;
  cls_t                     cls;

  // Stall detection only exists in builds with the timeout feature; HOLD_MAX is otherwise inert.
  if (HOLD_MAX < 0) begin : g_hold_max_unused
  end

`ifdef ONEHOT_CHK_TIMEOUT_EN
  localparam int HW = $clog2(HOLD_MAX + 2);
  logic [HW-1:0] hold_cnt, hold_nxt;
`endif

  onehot_classify #(.WIDTH(WIDTH)) u_classify (
    .prev (prev),
    .s    (phase),
    .cls  (cls),
    .idx  (s_idx)
  );

  always_comb begin
    state_nxt   = state;
    prev_nxt    = prev;
    idx_nxt     = idx;
    match_nxt   = match_cnt;
    cnt_nxt     = err_count;
    adv_nxt     = 1'b0;
    err_nxt     = 1'b0;
    fault_entry = 1'b0;
`ifdef ONEHOT_CHK_TIMEOUT_EN
    hold_nxt    = hold_cnt;
`endif
    if (en) begin
      if (cls != CLS_ILLEGAL) begin
        prev_nxt = phase;
        idx_nxt  = s_idx;
      end
      case (state)
        SEARCH, FAULT: begin
          if (cls != CLS_ILLEGAL) begin
            state_nxt = ACQUIRE;
            match_nxt = '0;
          end
        end
        ACQUIRE: begin
          case (cls)
            CLS_ADV: begin
              if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                state_nxt = LOCKED;
                match_nxt = '0;
              end else begin
                match_nxt = match_cnt + MW'(1);
              end
            end
            CLS_SKIP:    match_nxt = '0;
            CLS_ILLEGAL: state_nxt = SEARCH;
            default:     ;
          endcase
        end
        default: begin
          case (cls)
            CLS_ADV: begin
              adv_nxt = 1'b1;
`ifdef ONEHOT_CHK_TIMEOUT_EN
              hold_nxt = '0;
`endif
            end
            CLS_HOLD: begin
`ifdef ONEHOT_CHK_TIMEOUT_EN
              if (hold_cnt == HW'(HOLD_MAX)) fault_entry = 1'b1;
              else                           hold_nxt = hold_cnt + HW'(1);
`endif
            end
            default: fault_entry = 1'b1;
          endcase
        end
      endcase
      if (fault_entry) begin
        state_nxt = FAULT;
        err_nxt   = 1'b1;
        if (err_count != '1) cnt_nxt = err_count + ERR_CNT_WIDTH'(1);
`ifdef ONEHOT_CHK_TIMEOUT_EN
        hold_nxt  = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      prev      <= '0;
      match_cnt <= '0;
      idx       <= '0;
      locked    <= 1'b0;
      fault     <= 1'b0;
      adv_pulse <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
`ifdef ONEHOT_CHK_TIMEOUT_EN
      hold_cnt  <= '0;
`endif
    end else begin
      state     <= state_nxt;
      prev      <= prev_nxt;
      match_cnt <= match_nxt;
      idx       <= idx_nxt;
      locked    <= (state_nxt == LOCKED);
      fault     <= (state_nxt == FAULT);
      adv_pulse <= adv_nxt;
      err_pulse <= err_nxt;
      err_count <= cnt_nxt;
`ifdef ONEHOT_CHK_TIMEOUT_EN
      hold_cnt  <= hold_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_onehot_seq_checker.sv
// Scenario bench for onehot_seq_checker (WIDTH=4, LOCK_COUNT=2, ERR_CNT_WIDTH=2, HOLD_MAX=3).
module tb_onehot_seq_checker;

  typedef struct packed {
    logic [1:0] idx;
    logic       locked;
    logic       fault;
    logic       adv;
    logic       err;
    logic [1:0] cnt;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [3:0] ph;
    obs_t       exp;
  } row_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] phase = 4'b0000;
  logic [1:0] idx;
  logic       locked, fault, adv_pulse, err_pulse;
  logic [1:0] err_count;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];

  onehot_seq_checker #(
    .WIDTH(4), .LOCK_COUNT(2), .ERR_CNT_WIDTH(2), .HOLD_MAX(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .phase(phase),
    .idx(idx), .locked(locked), .fault(fault),
    .adv_pulse(adv_pulse), .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic row_t rw(input logic r, input logic e, input logic [3:0] p,
                              input logic [1:0] i, input logic l, input logic f,
                              input logic a, input logic er, input logic [1:0] c);
    row_t x;
    x.rst = r; x.en = e; x.ph = p;
    x.exp = '{idx: i, locked: l, fault: f, adv: a, err: er, cnt: c};
    return x;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = '{idx: idx, locked: locked, fault: fault, adv: adv_pulse, err: err_pulse, cnt: err_count};
    return o;
  endfunction

  // Drive one sample at the falling edge, queue its expected result, settle past the rising edge.
  task automatic drive(input row_t r);
    @(negedge clk);
    rst = r.rst; en = r.en; phase = r.ph;
    exp_q.push_back(r.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t r[$];
    obs_t e, got;
    r.push_back(rw(1, 1, 4'b0001, 0, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 0, 4'b0001, 0, 0, 0, 0, 0, 0));
    foreach (r[i]) begin
      drive(r[i]);
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset[%0d]: got %b expected %b", i, got, e); end
    end
  endtask

  task automatic test_lockup();
    row_t r[$];
    obs_t e, got;
    r.push_back(rw(0, 1, 4'b0001, 0, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0010, 1, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0100, 2, 1, 0, 0, 0, 0));
    r.push_back(rw(0, 0, 4'b1000, 2, 1, 0, 0, 0, 0));
    foreach (r[i]) begin
      drive(r[i]);
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e) begin errors++; $display("FAIL lockup[%0d]: got %b expected %b", i, got, e); end
    end
  endtask

  task automatic test_wrap();
    row_t r[$];
    obs_t e, got;
    r.push_back(rw(0, 1, 4'b1000, 3, 1, 0, 1, 0, 0));
    r.push_back(rw(0, 1, 4'b0001, 0, 1, 0, 1, 0, 0));
    r.push_back(rw(0, 0, 4'b0010, 0, 1, 0, 0, 0, 0));
    foreach (r[i]) begin
      drive(r[i]);
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e) begin errors++; $display("FAIL wrap[%0d]: got %b expected %b", i, got, e); end
    end
  endtask

  task automatic test_skip();
    row_t r[$];
    obs_t e, got;
    r.push_back(rw(0, 1, 4'b0010, 1, 1, 0, 1, 0, 0));
    r.push_back(rw(0, 1, 4'b1000, 3, 0, 1, 0, 1, 1));
    r.push_back(rw(0, 1, 4'b0000, 3, 0, 1, 0, 0, 1));
    r.push_back(rw(0, 1, 4'b0001, 0, 0, 0, 0, 0, 1));
    r.push_back(rw(0, 1, 4'b0010, 1, 0, 0, 0, 0, 1));
    r.push_back(rw(0, 1, 4'b0100, 2, 1, 0, 0, 0, 1));
    foreach (r[i]) begin
      drive(r[i]);
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e) begin errors++; $display("FAIL skip[%0d]: got %b expected %b", i, got, e); end
    end
  endtask

  task automatic test_illegal();
    row_t r[$];
    obs_t e, got;
    r.push_back(rw(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0110, 0, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0000, 0, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0100, 2, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0011, 2, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b1000, 3, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0001, 0, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0001, 0, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0010, 1, 1, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0000, 1, 0, 1, 0, 1, 1));
    r.push_back(rw(0, 1, 4'b0000, 1, 0, 1, 0, 0, 1));
    r.push_back(rw(0, 1, 4'b1111, 1, 0, 1, 0, 0, 1));
    foreach (r[i]) begin
      drive(r[i]);
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e) begin errors++; $display("FAIL illegal[%0d]: got %b expected %b", i, got, e); end
    end
  endtask

  task automatic test_saturation();
    row_t r[$];
    obs_t e, got;
    int cur, sat;
    r.push_back(rw(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0001, 0, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0010, 1, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0100, 2, 1, 0, 0, 0, 0));
    cur = 2;
    for (int k = 0; k < 5; k++) begin
      sat = (k + 1 > 3) ? 3 : k + 1;
      cur = (cur + 3) % 4;
      r.push_back(rw(0, 1, 4'b0001 << cur, 2'(cur), 0, 1, 0, 1, 2'(sat)));
      for (int t = 1; t <= 3; t++) begin
        cur = (cur + 1) % 4;
        r.push_back(rw(0, 1, 4'b0001 << cur, 2'(cur), (t == 3), 0, 0, 0, 2'(sat)));
      end
    end
    cur = (cur + 1) % 4;
    r.push_back(rw(1, 1, 4'b0001 << cur, 0, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0010, 1, 0, 0, 0, 0, 0));
    foreach (r[i]) begin
      drive(r[i]);
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e) begin errors++; $display("FAIL saturation[%0d]: got %b expected %b", i, got, e); end
    end
  endtask

`ifdef ONEHOT_CHK_TIMEOUT_EN
  task automatic test_stall();
    row_t r[$];
    obs_t e, got;
    r.push_back(rw(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0100, 2, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b1000, 3, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0001, 0, 1, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0001, 0, 1, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0001, 0, 1, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0010, 1, 1, 0, 1, 0, 0));
    r.push_back(rw(0, 1, 4'b0010, 1, 1, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0010, 1, 1, 0, 0, 0, 0));
    r.push_back(rw(0, 0, 4'b0010, 1, 1, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0010, 1, 1, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0010, 1, 0, 1, 0, 1, 1));
    r.push_back(rw(0, 1, 4'b0000, 1, 0, 1, 0, 0, 1));
    foreach (r[i]) begin
      drive(r[i]);
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e) begin errors++; $display("FAIL stall[%0d]: got %b expected %b", i, got, e); end
    end
  endtask
`else
  task automatic test_hold_tolerated();
    row_t r[$];
    obs_t e, got;
    r.push_back(rw(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0100, 2, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b1000, 3, 0, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0001, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 6; k++) r.push_back(rw(0, 1, 4'b0001, 0, 1, 0, 0, 0, 0));
    r.push_back(rw(0, 1, 4'b0010, 1, 1, 0, 1, 0, 0));
    foreach (r[i]) begin
      drive(r[i]);
      e = exp_q.pop_front(); got = observe(); checks++;
      if (got !== e) begin errors++; $display("FAIL hold_tolerated[%0d]: got %b expected %b", i, got, e); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lockup();
    test_wrap();
    test_skip();
    test_illegal();
    test_saturation();
`ifdef ONEHOT_CHK_TIMEOUT_EN
    test_stall();
`else
    test_hold_tolerated();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
